// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and flush.
// Optional saturating stall counter enabled by PIPE_STALL_CNT_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 2,
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [IDX_W-1:0]  main_idx_q, main_idx_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [IDX_W-1:0]  skid_idx_q, skid_idx_d;
    logic              in_fire;
    logic              out_fire;

    // Ready depends only on the state register, breaking the ready chain.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign out_idx   = main_idx_q;
    assign occupancy = state_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        main_idx_d  = main_idx_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        skid_idx_d  = skid_idx_q;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        main_idx_d  = in_idx;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        main_idx_d  = in_idx;
                    end else if (in_fire) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        skid_idx_d  = in_idx;
                        state_d     = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        main_idx_d  = skid_idx_q;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_idx_q  <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            main_idx_q  <= main_idx_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_idx_q  <= skid_idx_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturates rather than wraps; flush does not touch it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue models the held entries.
// Stall counter checks are built when PIPE_STALL_CNT_EN is defined.
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 2;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
        logic [IDX_W-1:0]  i;
    } ent_t;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  in_idx;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic [1:0]        occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  stall_m;
`endif

    int   n_chk;
    int   n_fail;
    ent_t q[$];

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .in_idx   (in_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .out_idx  (out_idx),
        .occupancy(occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model update and output comparison, away from the active edge.
    always @(negedge clk) begin
        int   n;
        bit   in_f;
        bit   out_f;
        ent_t e;
        if (!reset) begin
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
            chk("rst_out_data", 128'(out_data), 128'(0));
            chk("rst_out_idx", 128'(out_idx), 128'(0));
            chk("rst_occupancy", 128'(occupancy), 128'(0));
            chk("rst_in_ready", 128'(in_ready), 128'(1));
`ifdef PIPE_STALL_CNT_EN
            chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
            stall_m = '0;
`endif
            q.delete();
        end else begin
            n = q.size();
            chk("occupancy", 128'(occupancy), 128'(n));
            chk("in_ready", 128'(in_ready), 128'(n < 2));
            chk("out_valid", 128'(out_valid), 128'(n > 0));
            if (n > 0) begin
                chk("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
                chk("out_data", 128'(out_data), 128'(q[0].d));
                chk("out_idx", 128'(out_idx), 128'(q[0].i));
            end else begin
                chk("out_ctrl_idle", 128'(out_ctrl), 128'(0));
            end
`ifdef PIPE_STALL_CNT_EN
            chk("stall_cnt", 128'(stall_cnt), 128'(stall_m));
            if (n > 0 && !out_ready && stall_m != '1) stall_m = stall_m + 1'b1;
`endif
            in_f  = in_valid && (n < 2);
            out_f = (n > 0) && out_ready;
            if (out_f) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (in_f) begin
                e.c = in_ctrl;
                e.d = in_data;
                e.i = in_idx;
                q.push_back(e);
            end
        end
    end

    task automatic cyc(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i,
                       input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        in_idx    = i;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        in_idx    = '0;
        out_ready = 1'b0;
`ifdef PIPE_STALL_CNT_EN
        stall_m   = '0;
`endif
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming at full rate.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, CTRL_W'(k), DATA_W'(k), IDX_W'(k), 1'b1, 1'b0);
        end
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Backpressure absorbed by the skid entry.
        cyc(1'b1, 2'b01, 64'hAAAA, 5'd10, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 64'hBBBB, 5'd11, 1'b0, 1'b0);
        chk("bp_full_occ", 128'(occupancy), 128'(2));
        chk("bp_full_rdy", 128'(in_ready), 128'(0));
        chk("bp_head_A", 128'(out_data), 128'(64'hAAAA));
        cyc(1'b1, 2'b11, 64'hCCCC, 5'd12, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("bp_head_B", 128'(out_data), 128'(64'hBBBB));
        chk("bp_rdy_back", 128'(in_ready), 128'(1));
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Flush while full; concurrent entry is dropped.
        cyc(1'b1, 2'b11, 64'h1111, 5'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 64'h2222, 5'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 64'h3333, 5'd3, 1'b0, 1'b1);
        chk("fl_valid", 128'(out_valid), 128'(0));
        chk("fl_ctrl", 128'(out_ctrl), 128'(0));
        chk("fl_occ", 128'(occupancy), 128'(0));
        chk("fl_rdy", 128'(in_ready), 128'(1));
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Flush with one held and both handshakes firing.
        cyc(1'b1, 2'b01, 64'h4444, 5'd4, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 64'h5555, 5'd5, 1'b1, 1'b1);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("fl1_valid", 128'(out_valid), 128'(0));

        // Asynchronous reset between edges while stalled and full.
        cyc(1'b1, 2'b11, 64'h6666, 5'd6, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 64'h7777, 5'd7, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("ar_valid", 128'(out_valid), 128'(0));
        chk("ar_data", 128'(out_data), 128'(0));
        chk("ar_rdy", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b1, 2'b01, 64'h8888, 5'd8, 1'b1, 1'b0);
        chk("ar_new_data", 128'(out_data), 128'(64'h8888));
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);

`ifdef PIPE_STALL_CNT_EN
        cyc(1'b1, 2'b01, 64'h9999, 5'd9, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("sc_sat", 128'(stall_cnt), 128'(15));
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("sc_flush", 128'(stall_cnt), 128'(15));
        reset = 1'b0;
        #1;
        chk("sc_reset", 128'(stall_cnt), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
`endif

        // Random traffic with occasional flush.
        for (int k = 0; k < 300; k++) begin
            cyc(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom),
                {$urandom, $urandom}, IDX_W'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end
        repeat (3) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
